// File: rtl/mul_arb_pkg.sv
// Shared constants and the rotate-priority search used by the multiplier-cell arbiter.
package mul_arb_pkg;

  localparam int ARB_DATA_W      = 32;
  localparam int MAX_REQ         = 8;
  localparam int DEF_MUL_LATENCY = 1;

  // Lowest set bit at or above the priority pointer, falling back to the lowest
  // set bit overall. upper_mask has ones from the pointer position upward, so the
  // fallback is the wrap-around part of the search.
  function automatic logic [MAX_REQ-1:0] rr_onehot(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_REQ-1:0] upper_mask
  );
    logic [MAX_REQ-1:0] upper;
    logic [MAX_REQ-1:0] pick;
    upper = req & upper_mask;
    if (upper != {MAX_REQ{1'b0}}) begin
      pick = upper & (~upper + MAX_REQ'(1'b1));
    end else begin
      pick = req & (~req + MAX_REQ'(1'b1));
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index; owns the priority pointer.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_REQ-1:0] mask_s;
  logic [MAX_REQ-1:0] pick_s;

  // Rotate-priority search from the pointer; gated off entirely when not enabled.
  always_comb begin
    req_ext_s              = {MAX_REQ{1'b0}};
    req_ext_s[NUM_REQ-1:0] = req;
    mask_s                 = {MAX_REQ{1'b1}} << ptr_q;
    pick_s                 = rr_onehot(req_ext_s, mask_s);
    if (en) begin
      grant = pick_s[NUM_REQ-1:0];
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

  // One-hot to index encode; grant is at most one-hot so OR-ing is exact.
  always_comb begin
    grant_id = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_id = grant_id | ({ID_W{grant[i]}} & ID_W'(i));
    end
  end

  // Next pointer: one past the winner with wrap, unchanged when nothing transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) begin
        ptr_d = {ID_W{1'b0}};
      end else begin
        ptr_d = grant_id + ID_W'(1'b1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= {ID_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_cell_arbiter.sv
// Shares one pipelined multiplier cell among NUM_REQ requesters, returning
// tagged products in issue order after the cell's fixed latency.
module mul_cell_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [NUM_REQ-1:0]               grant_s;
  logic [ID_W-1:0]                  grant_id_s;
  logic                             arb_en_s;
  logic                             transfer_s;
  logic [MUL_LATENCY-1:0]           tag_v_q;
  logic [MUL_LATENCY-1:0]           tag_v_d;
  logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_q;
  logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_d;

  // No grants while held or while reset is asserted; the cell never back-pressures.
  assign arb_en_s   = ~hold & ~reset;
  assign transfer_s = |(grant_s & req_valid);
  assign req_ready  = grant_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .en       (arb_en_s),
    .advance  (transfer_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Operand mux: granted requester's slices, zero when idle (cell registers its inputs).
  always_comb begin
    mul_src1 = {DATA_W{1'b0}};
    mul_src2 = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_src1 = mul_src1 | ({DATA_W{grant_s[i]}} & req_src1[i*DATA_W +: DATA_W]);
      mul_src2 = mul_src2 | ({DATA_W{grant_s[i]}} & req_src2[i*DATA_W +: DATA_W]);
    end
  end

  // Tag shift: stage 0 takes this cycle's issue, later stages follow the cell pipeline.
  always_comb begin
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = transfer_s;
    tag_id_d[0] = grant_id_s;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
  end

  // Tag pipeline registers; reset drops every in-flight tag, matching the cell's aclr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v_q  <= {MUL_LATENCY{1'b0}};
      tag_id_q <= {(MUL_LATENCY*ID_W){1'b0}};
    end else begin
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  assign rsp_valid = tag_v_q[MUL_LATENCY-1];
  assign rsp_id    = tag_id_q[MUL_LATENCY-1];
  assign rsp_data  = rsp_valid ? mul_result : {DATA_W{1'b0}};
  assign busy      = |tag_v_q;

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Scoreboard bench for mul_cell_arbiter with a behavioural multiplier cell.
module tb_mul_cell_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_src1 = '0;
  logic [N*DW-1:0]   req_src2 = '0;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     mul_src1, mul_src2, mul_result;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  mul_cell_arbiter #(.NUM_REQ(N), .MUL_LATENCY(LAT), .DATA_W(DW), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier cell stand-in: LAT register stages, cleared by reset like the real aclr.
  logic [DW-1:0] cell_pipe [LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) cell_pipe[s] <= '0;
    end else begin
      cell_pipe[0] <= mul_src1 * mul_src2;
      for (int s = 1; s < LAT; s++) cell_pipe[s] <= cell_pipe[s-1];
    end
  end
  assign mul_result = cell_pipe[LAT-1];

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            ptr_m = 0;
  int            last_issue = -100;
  logic [DW-1:0] opa [N];
  logic [DW-1:0] opb [N];
  logic [N-1:0]  pend = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check combinational outputs at negedge,
  // and push the expected product for any transfer.
  task automatic cycle_drive(input logic [N-1:0] v, input logic h, input logic r, output int g);
    int            exp_id;
    int            idx;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] e1, e2;
    logic          exp_busy;
    exp_t          e;
    @(posedge clk);
    #1;
    reset = r;
    hold = h;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_src1[i*DW +: DW] = opa[i];
      req_src2[i*DW +: DW] = opb[i];
    end
    if (r) begin
      sb_q.delete();
      ptr_m = 0;
      last_issue = -100;
    end
    @(negedge clk);
    exp_id = -1;
    if (!r && !h) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (exp_id < 0 && v[idx]) exp_id = idx;
      end
    end
    exp_rdy = '0;
    e1 = '0;
    e2 = '0;
    if (exp_id >= 0) begin
      exp_rdy[exp_id] = 1'b1;
      e1 = opa[exp_id];
      e2 = opb[exp_id];
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("mul_src", {mul_src1, mul_src2}, {e1, e2});
    exp_busy = (cyc - last_issue >= 1) && (cyc - last_issue <= LAT);
    check("busy", 64'(busy), 64'(exp_busy));
    if (r) check("reset_rsp", {61'd0, rsp_valid, rsp_id}, 64'd0);
    if (exp_id >= 0) begin
      e.id = exp_id;
      e.data = opa[exp_id] * opb[exp_id];
      e.due = cyc + LAT;
      sb_q.push_back(e);
      ptr_m = (exp_id + 1) % N;
      last_issue = cyc;
    end
    g = exp_id;
  endtask

  // Repeat a request pattern; a granted requester gets fresh operands.
  task automatic run(input logic [N-1:0] v, input logic h, input int cycles);
    int g;
    for (int c = 0; c < cycles; c++) begin
      cycle_drive(v, h, 1'b0, g);
      if (g >= 0) begin
        opa[g] = $urandom;
        opb[g] = $urandom;
      end
    end
  endtask

  // Response monitor: every cycle either the queue head is due and must appear, or nothing may.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check("rsp_valid_due", 64'(rsp_valid), 64'd1);
      if (rsp_valid) begin
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'd0);
    end
  end

  initial begin
    int g;
    for (int i = 0; i < N; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
    end
    // Reset state.
    cycle_drive(4'b0000, 1'b0, 1'b1, g);
    cycle_drive(4'b1111, 1'b0, 1'b1, g);
    // Single request 7*6.
    opa[0] = 32'h0000_0007;
    opb[0] = 32'h0000_0006;
    run(4'b0001, 1'b0, 1);
    run(4'b0000, 1'b0, LAT + 2);
    // All four valid: strict rotation, one result per cycle.
    run(4'b1111, 1'b0, 8);
    // Requesters 1 and 3 only: alternate, skipping 0 on wrap.
    run(4'b1010, 1'b0, 6);
    run(4'b0000, 1'b0, LAT + 1);
    // Advance pointer to 2, then hold with everyone valid, then release.
    run(4'b0010, 1'b0, 1);
    run(4'b1111, 1'b1, 5);
    run(4'b1111, 1'b0, 3);
    run(4'b0000, 1'b0, LAT + 1);
    // Reset in the middle of back-to-back issues drops all in-flight tags.
    run(4'b1111, 1'b0, 2);
    cycle_drive(4'b1111, 1'b0, 1'b1, g);
    cycle_drive(4'b1111, 1'b0, 1'b1, g);
    run(4'b0000, 1'b0, LAT + 2);
    run(4'b1111, 1'b0, 2);
    run(4'b0000, 1'b0, LAT + 1);
    // Large operands: low 32 bits only.
    opa[2] = 32'hFFFF_FFFF;
    opb[2] = 32'h0000_0002;
    run(4'b0100, 1'b0, 1);
    opa[1] = 32'h0001_0000;
    opb[1] = 32'h0001_0000;
    run(4'b0010, 1'b0, 1);
    run(4'b0000, 1'b0, LAT + 1);
    // Randomized traffic with drops and hold toggling.
    for (int c = 0; c < 300; c++) begin
      logic h;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          opa[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
          opb[i] = $urandom;
        end else if (pend[i] && $urandom_range(0, 99) < 5) begin
          pend[i] = 1'b0;
        end
      end
      h = ($urandom_range(0, 99) < 12);
      cycle_drive(pend, h, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    run(4'b0000, 1'b0, LAT + 2);
    check("drain_queue", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
